// File: rtl/bmp_pkg.sv
// Shared types and constants for the BMP byte-stream reader.
package bmp_pkg;

    localparam int unsigned BMP_HDR_BYTES = 54;
    // 'BM' read little-endian: byte 0 = 'B' (0x42), byte 1 = 'M' (0x4D).
    localparam logic [15:0] BMP_TYPE      = 16'h4D42;
    localparam logic [15:0] BMP_BPP       = 16'd24;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StCheck,
        StSkip,
        StPix,
        StPad,
        StDone,
        StErr
    } bmp_rd_state_t;

    typedef enum logic [2:0] {
        ErrNone   = 3'd0,
        ErrType   = 3'd1,
        ErrBpp    = 3'd2,
        ErrComp   = 3'd3,
        ErrWidth  = 3'd4,
        ErrHeight = 3'd5,
        ErrOffset = 3'd6
    } bmp_err_t;

endpackage

// File: rtl/bmp_hdr_capture.sv
// Header byte counter and field registers for the 54-byte BMP header.
module bmp_hdr_capture
    import bmp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        capture_i,
    input  logic [7:0]  byte_i,
    output logic        done_o,
    output logic [15:0] bf_type_o,
    output logic [31:0] bf_off_bits_o,
    output logic [31:0] bi_width_o,
    output logic [31:0] bi_height_o,
    output logic [15:0] bi_bit_count_o,
    output logic [31:0] bi_compression_o
);

    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] bf_type_q, bf_type_d;
    logic [31:0] bf_off_bits_q, bf_off_bits_d;
    logic [31:0] bi_width_q, bi_width_d;
    logic [31:0] bi_height_q, bi_height_d;
    logic [15:0] bi_bit_count_q, bi_bit_count_d;
    logic [31:0] bi_compression_q, bi_compression_d;

    // Store each accepted byte at its header offset; bytes of unused fields are dropped.
    always_comb begin
        cnt_d            = cnt_q;
        bf_type_d        = bf_type_q;
        bf_off_bits_d    = bf_off_bits_q;
        bi_width_d       = bi_width_q;
        bi_height_d      = bi_height_q;
        bi_bit_count_d   = bi_bit_count_q;
        bi_compression_d = bi_compression_q;
        if (clear_i) begin
            cnt_d            = '0;
            bf_type_d        = '0;
            bf_off_bits_d    = '0;
            bi_width_d       = '0;
            bi_height_d      = '0;
            bi_bit_count_d   = '0;
            bi_compression_d = '0;
        end else if (capture_i) begin
            cnt_d = cnt_q + 6'd1;
            case (cnt_q)
                6'd0:  bf_type_d[7:0]          = byte_i;
                6'd1:  bf_type_d[15:8]         = byte_i;
                6'd10: bf_off_bits_d[7:0]      = byte_i;
                6'd11: bf_off_bits_d[15:8]     = byte_i;
                6'd12: bf_off_bits_d[23:16]    = byte_i;
                6'd13: bf_off_bits_d[31:24]    = byte_i;
                6'd18: bi_width_d[7:0]         = byte_i;
                6'd19: bi_width_d[15:8]        = byte_i;
                6'd20: bi_width_d[23:16]       = byte_i;
                6'd21: bi_width_d[31:24]       = byte_i;
                6'd22: bi_height_d[7:0]        = byte_i;
                6'd23: bi_height_d[15:8]       = byte_i;
                6'd24: bi_height_d[23:16]      = byte_i;
                6'd25: bi_height_d[31:24]      = byte_i;
                6'd28: bi_bit_count_d[7:0]     = byte_i;
                6'd29: bi_bit_count_d[15:8]    = byte_i;
                6'd30: bi_compression_d[7:0]   = byte_i;
                6'd31: bi_compression_d[15:8]  = byte_i;
                6'd32: bi_compression_d[23:16] = byte_i;
                6'd33: bi_compression_d[31:24] = byte_i;
                default: ;
            endcase
        end
    end

    // Counter and field registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q            <= '0;
            bf_type_q        <= '0;
            bf_off_bits_q    <= '0;
            bi_width_q       <= '0;
            bi_height_q      <= '0;
            bi_bit_count_q   <= '0;
            bi_compression_q <= '0;
        end else begin
            cnt_q            <= cnt_d;
            bf_type_q        <= bf_type_d;
            bf_off_bits_q    <= bf_off_bits_d;
            bi_width_q       <= bi_width_d;
            bi_height_q      <= bi_height_d;
            bi_bit_count_q   <= bi_bit_count_d;
            bi_compression_q <= bi_compression_d;
        end
    end

    assign done_o           = capture_i && !clear_i && (cnt_q == 6'(BMP_HDR_BYTES - 1));
    assign bf_type_o        = bf_type_q;
    assign bf_off_bits_o    = bf_off_bits_q;
    assign bi_width_o       = bi_width_q;
    assign bi_height_o      = bi_height_q;
    assign bi_bit_count_o   = bi_bit_count_q;
    assign bi_compression_o = bi_compression_q;

endmodule

// File: rtl/bmp_stream_reader.sv
// Streaming 24-bit BMP decoder: header check, offset skip, pad removal, pixel output.
module bmp_stream_reader
    import bmp_pkg::*;
#(
    parameter int unsigned HRES = 320,
    parameter int unsigned VRES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_pix_valid,
    output logic [23:0] o_pix_data,
    input  logic        i_pix_ready,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_bottom_up,
    output logic        o_busy,
    output logic        o_err,
    output logic [2:0]  o_err_code
);

    localparam int unsigned PAD  = (4 - (HRES * 3) % 4) % 4;
    localparam int unsigned ColW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int unsigned RowW = (VRES > 1) ? $clog2(VRES) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(HRES - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(VRES - 1);

    bmp_rd_state_t   state_q, state_d;
    bmp_err_t        err_code_q, err_code_d;
    logic            err_q, err_d;
    logic            bottom_up_q, bottom_up_d;
    logic [31:0]     skip_q, skip_d;
    logic [1:0]      phase_q, phase_d;
    logic [15:0]     hold_q, hold_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            frame_end_q, frame_end_d;
    logic            pix_valid_q, pix_valid_d;
    logic [23:0]     pix_data_q, pix_data_d;
    logic            sof_q, sof_d;
    logic            eol_q, eol_d;
    logic            eof_q, eof_d;

    logic        accept;
    logic        hdr_done;
    logic [15:0] bf_type;
    logic [31:0] bf_off_bits;
    logic [31:0] bi_width;
    logic [31:0] bi_height;
    logic [15:0] bi_bit_count;
    logic [31:0] bi_compression;
    logic [31:0] height_abs;

    // A byte arriving together with i_start is dropped.
    assign accept     = i_byte_valid && o_byte_ready && !i_start;
    assign height_abs = bi_height[31] ? (~bi_height + 32'd1) : bi_height;

    bmp_hdr_capture u_hdr (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (i_start),
        .capture_i        (accept && (state_q == StHdr)),
        .byte_i           (i_byte),
        .done_o           (hdr_done),
        .bf_type_o        (bf_type),
        .bf_off_bits_o    (bf_off_bits),
        .bi_width_o       (bi_width),
        .bi_height_o      (bi_height),
        .bi_bit_count_o   (bi_bit_count),
        .bi_compression_o (bi_compression)
    );

    // Byte-side ready: pixel bytes stall only while the output register is full and blocked.
    always_comb begin
        o_byte_ready = 1'b0;
        unique case (state_q)
            StHdr, StSkip, StPad: o_byte_ready = 1'b1;
            StPix:                o_byte_ready = !pix_valid_q || i_pix_ready;
            default:              o_byte_ready = 1'b0;
        endcase
    end

    // Next-state logic for the parser FSM and the pixel datapath.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        bottom_up_d = bottom_up_q;
        skip_d      = skip_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_end_d = frame_end_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        eof_d       = eof_q;

        if (i_start) begin
            state_d     = StHdr;
            err_d       = 1'b0;
            err_code_d  = ErrNone;
            bottom_up_d = 1'b0;
            skip_d      = '0;
            phase_d     = '0;
            hold_d      = '0;
            col_d       = '0;
            row_d       = '0;
            frame_end_d = 1'b0;
            pix_valid_d = 1'b0;
            sof_d       = 1'b0;
            eol_d       = 1'b0;
            eof_d       = 1'b0;
        end else begin
            if (pix_valid_q && i_pix_ready) begin
                pix_valid_d = 1'b0;
            end
            unique case (state_q)
                StHdr: begin
                    if (hdr_done) state_d = StCheck;
                end
                StCheck: begin
                    bottom_up_d = !bi_height[31];
                    skip_d      = bf_off_bits - 32'(BMP_HDR_BYTES);
                    err_d       = 1'b1;
                    state_d     = StErr;
                    if (bf_type != BMP_TYPE) begin
                        err_code_d = ErrType;
                    end else if (bi_bit_count != BMP_BPP) begin
                        err_code_d = ErrBpp;
                    end else if (bi_compression != 32'd0) begin
                        err_code_d = ErrComp;
                    end else if (bi_width != 32'(HRES)) begin
                        err_code_d = ErrWidth;
                    end else if (height_abs != 32'(VRES)) begin
                        err_code_d = ErrHeight;
                    end else if (bf_off_bits < 32'(BMP_HDR_BYTES)) begin
                        err_code_d = ErrOffset;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (bf_off_bits == 32'(BMP_HDR_BYTES)) ? StPix : StSkip;
                    end
                end
                StSkip, StPad: begin
                    // skip_q counts remaining discard bytes for both the offset gap and row pad.
                    if (accept) begin
                        skip_d = skip_q - 32'd1;
                        if (skip_q == 32'd1) begin
                            if (state_q == StSkip) state_d = StPix;
                            else                   state_d = frame_end_q ? StDone : StPix;
                        end
                    end
                end
                StPix: begin
                    if (accept) begin
                        unique case (phase_q)
                            2'd0: begin
                                hold_d[7:0] = i_byte;
                                phase_d     = 2'd1;
                            end
                            2'd1: begin
                                hold_d[15:8] = i_byte;
                                phase_d      = 2'd2;
                            end
                            default: begin
                                phase_d     = 2'd0;
                                pix_valid_d = 1'b1;
                                pix_data_d  = {i_byte, hold_q[15:8], hold_q[7:0]};
                                sof_d       = (col_q == '0) && (row_q == '0);
                                eol_d       = (col_q == ColLast);
                                eof_d       = (col_q == ColLast) && (row_q == RowLast);
                                if (col_q == ColLast) begin
                                    col_d = '0;
                                    if (row_q == RowLast) frame_end_d = 1'b1;
                                    else                  row_d = row_q + RowW'(1);
                                    if (PAD > 0) begin
                                        state_d = StPad;
                                        skip_d  = 32'(PAD);
                                    end else if (row_q == RowLast) begin
                                        state_d = StDone;
                                    end
                                end else begin
                                    col_d = col_q + ColW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
            bottom_up_q <= 1'b0;
            skip_q      <= '0;
            phase_q     <= '0;
            hold_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            frame_end_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            bottom_up_q <= bottom_up_d;
            skip_q      <= skip_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_end_q <= frame_end_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
        end
    end

    assign o_pix_valid = pix_valid_q;
    assign o_pix_data  = pix_data_q;
    assign o_sof       = sof_q;
    assign o_eol       = eol_q;
    assign o_eof       = eof_q;
    assign o_bottom_up = bottom_up_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_busy      = !(state_q inside {StIdle, StDone, StErr});

endmodule

// File: tb/tb_bmp_stream_reader.sv
// Scoreboard bench for bmp_stream_reader at a small resolution with row padding.
module tb_bmp_stream_reader;

    localparam int unsigned HRES = 3;
    localparam int unsigned VRES = 2;
    localparam int unsigned PAD  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready;
    logic        o_pix_valid;
    logic [23:0] o_pix_data;
    logic        i_pix_ready = 1'b0;
    logic        o_sof, o_eol, o_eof, o_bottom_up, o_busy, o_err;
    logic [2:0]  o_err_code;

    always #5 clk = ~clk;

    bmp_stream_reader #(.HRES(HRES), .VRES(VRES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_pix_valid  (o_pix_valid),
        .o_pix_data   (o_pix_data),
        .i_pix_ready  (i_pix_ready),
        .o_sof        (o_sof),
        .o_eol        (o_eol),
        .o_eof        (o_eof),
        .o_bottom_up  (o_bottom_up),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] file_q[$];
    int         checks = 0;
    int         failures = 0;
    int         pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
    int         ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
    logic       stall_prev = 1'b0;
    logic [23:0] stall_data = '0;
    bit         ok;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream model: drive ready at negedge, sample handshakes just before posedge.
    always @(negedge clk) begin
        exp_t e;
        case (ready_mode)
            0:       i_pix_ready = 1'b0;
            1:       i_pix_ready = 1'b1;
            default: i_pix_ready = 1'($urandom_range(0, 1));
        endcase
        #4;
        if (ready_mode == 2 && stall_prev) begin
            check_eq("stall_valid", 32'(o_pix_valid), 32'd1);
            check_eq("stall_data", 32'(o_pix_data), 32'(stall_data));
        end
        stall_prev = (ready_mode == 2) && o_pix_valid && !i_pix_ready;
        stall_data = o_pix_data;
        if (o_pix_valid && i_pix_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("pix_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("pix_data", 32'(o_pix_data), 32'(e.data));
                check_eq("pix_sof", 32'(o_sof), 32'(e.sof));
                check_eq("pix_eol", 32'(o_eol), 32'(e.eol));
                check_eq("pix_eof", 32'(o_eof), 32'(e.eof));
            end
            pix_cnt++;
            if (o_sof) sof_cnt++;
            if (o_eol) eol_cnt++;
            if (o_eof) eof_cnt++;
        end
    end

    task automatic put32(input int off, input logic [31:0] v);
        for (int k = 0; k < 4; k++) file_q[off + k] = v[8*k +: 8];
    endtask

    task automatic build_file(input logic [15:0] bf_type, input logic [31:0] off,
                              input logic [31:0] width, input logic [31:0] height,
                              input logic [15:0] bpp, input logic [31:0] comp,
                              input int junk, input bit pixels, input logic [7:0] seed);
        int   k;
        logic [7:0] b, g, r;
        file_q.delete();
        for (int i = 0; i < 54; i++) file_q.push_back(8'h00);
        file_q[0] = bf_type[7:0];
        file_q[1] = bf_type[15:8];
        put32(2, 32'(54 + junk + VRES * (HRES * 3 + PAD)));
        put32(10, off);
        put32(14, 32'd40);
        put32(18, width);
        put32(22, height);
        file_q[26] = 8'd1;
        file_q[28] = bpp[7:0];
        file_q[29] = bpp[15:8];
        put32(30, comp);
        for (int j = 0; j < junk; j++) file_q.push_back(8'(8'hE0 + j));
        if (pixels) begin
            k = 0;
            for (int row = 0; row < VRES; row++) begin
                for (int col = 0; col < HRES; col++) begin
                    b = 8'(seed + 8'(3 * k));
                    g = 8'(seed + 8'(3 * k + 1));
                    r = 8'(seed + 8'(3 * k + 2));
                    file_q.push_back(b);
                    file_q.push_back(g);
                    file_q.push_back(r);
                    exp_q.push_back('{data: {r, g, b},
                                      sof: (row == 0 && col == 0),
                                      eol: (col == HRES - 1),
                                      eof: (col == HRES - 1 && row == VRES - 1)});
                    k++;
                end
                for (int p = 0; p < PAD; p++) file_q.push_back(8'hA5);
            end
        end
    endtask

    task automatic send_bytes(input int n, input bit rnd, output bit ok_o);
        int budget;
        int gap;
        bit accepted;
        ok_o = 1'b1;
        for (int i = 0; i < n && i < file_q.size(); i++) begin
            if (rnd) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(negedge clk);
                    i_byte_valid = 1'b0;
                end
            end
            @(negedge clk);
            i_byte_valid = 1'b1;
            i_byte = file_q[i];
            budget = 0;
            accepted = 1'b0;
            while (!accepted) begin
                #4;
                if (o_byte_ready) begin
                    accepted = 1'b1;
                    @(posedge clk);
                end else begin
                    budget++;
                    if (budget > 200) begin
                        check_eq("byte_ready_timeout", 32'(o_byte_ready), 32'd1);
                        ok_o = 1'b0;
                        i_byte_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || o_pix_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_counts();
        pix_cnt = 0;
        sof_cnt = 0;
        eol_cnt = 0;
        eof_cnt = 0;
    endtask

    task automatic check_frame(input logic exp_bottom_up);
        check_eq("pix_cnt", 32'(pix_cnt), 32'(HRES * VRES));
        check_eq("sof_cnt", 32'(sof_cnt), 32'd1);
        check_eq("eol_cnt", 32'(eol_cnt), 32'(VRES));
        check_eq("eof_cnt", 32'(eof_cnt), 32'd1);
        check_eq("frame_err", 32'(o_err), 32'd0);
        check_eq("bottom_up", 32'(o_bottom_up), 32'(exp_bottom_up));
        check_eq("done_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bt, bpp;
        logic [31:0] off, w, h, comp;

        repeat (3) @(negedge clk);
        check_eq("rst_byte_ready", 32'(o_byte_ready), 32'd0);
        check_eq("rst_pix_valid", 32'(o_pix_valid), 32'd0);
        check_eq("rst_pix_data", 32'(o_pix_data), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_err", 32'(o_err), 32'd0);
        check_eq("rst_err_code", 32'(o_err_code), 32'd0);
        check_eq("rst_bottom_up", 32'(o_bottom_up), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate frame, bottom-up.
        ready_mode = 1;
        clear_counts();
        pulse_start();
        check_eq("hdr_busy", 32'(o_busy), 32'd1);
        check_eq("hdr_ready", 32'(o_byte_ready), 32'd1);
        build_file(16'h4D42, 32'd54, 32'(HRES), 32'(VRES), 16'd24, 32'd0, 0, 1'b1, 8'h10);
        send_bytes(file_q.size(), 1'b0, ok);
        wait_drain("drain_full");
        check_frame(1'b1);
        @(negedge clk);
        i_byte_valid = 1'b1;
        i_byte = 8'h77;
        #4;
        check_eq("done_backpressure", 32'(o_byte_ready), 32'd0);
        @(negedge clk);
        i_byte_valid = 1'b0;

        // Pixel array at offset 58 behind four junk bytes.
        clear_counts();
        pulse_start();
        build_file(16'h4D42, 32'd58, 32'(HRES), 32'(VRES), 16'd24, 32'd0, 4, 1'b1, 8'h40);
        send_bytes(file_q.size(), 1'b0, ok);
        wait_drain("drain_skip");
        check_frame(1'b1);

        // Random byte gaps and random downstream ready.
        ready_mode = 2;
        clear_counts();
        pulse_start();
        build_file(16'h4D42, 32'd54, 32'(HRES), 32'(VRES), 16'd24, 32'd0, 0, 1'b1, 8'h10);
        send_bytes(file_q.size(), 1'b1, ok);
        wait_drain("drain_random");
        ready_mode = 1;
        check_frame(1'b1);

        // One header fault per run, error codes 1..6.
        clear_counts();
        for (int i = 1; i <= 6; i++) begin
            bt = 16'h4D42; off = 32'd54; w = 32'(HRES); h = 32'(VRES); bpp = 16'd24;
            comp = 32'd0;
            case (i)
                1:       bt = 16'h4142;
                2:       bpp = 16'd32;
                3:       comp = 32'd1;
                4:       w = 32'(HRES + 1);
                5:       h = 32'(VRES - 1);
                default: off = 32'd50;
            endcase
            pulse_start();
            build_file(bt, off, w, h, bpp, comp, 0, 1'b0, 8'h00);
            send_bytes(54, 1'b0, ok);
            check_eq("fault_check_err", 32'(o_err), 32'd0);
            check_eq("fault_check_ready", 32'(o_byte_ready), 32'd0);
            @(negedge clk);
            check_eq("fault_err", 32'(o_err), 32'd1);
            check_eq("fault_code", 32'(o_err_code), 32'(i));
            check_eq("fault_ready", 32'(o_byte_ready), 32'd0);
            check_eq("fault_busy", 32'(o_busy), 32'd0);
        end
        check_eq("fault_pix_cnt", 32'(pix_cnt), 32'd0);

        // Abort mid-PIX with a pixel pending, then a top-down frame.
        ready_mode = 0;
        pulse_start();
        build_file(16'h4D42, 32'd54, 32'(HRES), 32'(VRES), 16'd24, 32'd0, 0, 1'b1, 8'h80);
        send_bytes(54 + 3, 1'b0, ok);
        check_eq("abort_pending", 32'(o_pix_valid), 32'd1);
        pulse_start();
        check_eq("abort_valid_drop", 32'(o_pix_valid), 32'd0);
        exp_q.delete();
        ready_mode = 1;
        clear_counts();
        build_file(16'h4D42, 32'd54, 32'(HRES), 32'd0 - 32'(VRES), 16'd24, 32'd0, 0, 1'b1,
                   8'hC0);
        send_bytes(file_q.size(), 1'b0, ok);
        wait_drain("drain_topdown");
        check_frame(1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
